// File: rtl/tia_frame_capture.sv
// Captures the TIA pixel stream into a 160-wide framebuffer at y*H_PIXELS+x,
// clipping to H_PIXELS x V_LINES and signalling frame completion.
module tia_frame_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 240,
  parameter int V_SKIP   = 0,
  parameter int AW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic [6:0]    tia_color,
  input  logic          tia_hblank,
  input  logic          tia_vblank,
  input  logic          tia_vsync,
  output logic [AW-1:0] fb_addr,
  output logic [6:0]    fb_data,
  output logic          fb_we,
  output logic          frame_done,
  output logic [8:0]    lines_captured,
  output logic [2:0]    dbg_state_o
);

  localparam int XW = $clog2(H_PIXELS + 1);

  typedef enum logic [2:0] {
    S_WAIT_VSYNC  = 3'd0,
    S_WAIT_VBLANK = 3'd1,
    S_SKIP        = 3'd2,
    S_ACTIVE      = 3'd3,
    S_HOLD        = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic [8:0]    skip_q, skip_d;
  logic          hb_q, vb_q, vs_q;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [6:0]    fb_data_q, fb_data_d;
  logic          fb_we_q, fb_we_d;
  logic          frame_done_q, frame_done_d;
  logic [8:0]    lines_q, lines_d;

  logic          hb_rise, vb_rise, vb_fall, vs_rise, pix_vis;
  logic [XW-1:0] x_inc;

  assign hb_rise = pix_ce & tia_hblank & ~hb_q;
  assign vb_rise = pix_ce & tia_vblank & ~vb_q;
  assign vb_fall = pix_ce & ~tia_vblank & vb_q;
  assign vs_rise = pix_ce & tia_vsync & ~vs_q;
  assign pix_vis = pix_ce & ~tia_hblank & ~tia_vblank;
  assign x_inc   = (x_q == XW'(H_PIXELS)) ? x_q : x_q + XW'(1);

  // Write port: fb_we is a one-cycle strobe with no back-pressure; fb_addr and
  // fb_data are valid whenever fb_we is high and hold their last value otherwise.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    skip_d       = skip_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    fb_we_d      = 1'b0;
    frame_done_d = 1'b0;
    lines_d      = lines_q;

    if (vs_rise && state_q != S_WAIT_VSYNC) begin
      // Frame end outranks a coincident hblank rise, so y is reported unincremented.
      frame_done_d = 1'b1;
      lines_d      = y_q;
      state_d      = S_WAIT_VBLANK;
    end else begin
      case (state_q)
        S_WAIT_VSYNC: begin
          if (vs_rise) state_d = S_WAIT_VBLANK;
        end
        S_WAIT_VBLANK: begin
          if (vb_fall) begin
            skip_d      = 9'(V_SKIP);
            y_d         = '0;
            line_base_d = '0;
            x_d         = '0;
            state_d     = (V_SKIP > 0) ? S_SKIP : S_ACTIVE;
          end
        end
        S_SKIP: begin
          if (skip_q == 9'd0) begin
            state_d = S_ACTIVE;
          end else if (pix_vis) begin
            x_d = x_inc;
          end else if (hb_rise && x_q != '0) begin
            x_d    = '0;
            skip_d = skip_q - 9'd1;
            if (skip_q == 9'd1) state_d = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (pix_vis) begin
            if (x_q < XW'(H_PIXELS) && y_q < 9'(V_LINES)) begin
              fb_we_d   = 1'b1;
              fb_addr_d = line_base_q + AW'(x_q);
              fb_data_d = tia_color;
            end
            x_d = x_inc;
          end else if (hb_rise && x_q != '0) begin
            x_d = '0;
            if (y_q < 9'(V_LINES)) begin
              y_d         = y_q + 9'd1;
              line_base_d = line_base_q + AW'(H_PIXELS);
              if (y_q + 9'd1 == 9'(V_LINES)) state_d = S_HOLD;
            end
          end
          if (vb_rise) state_d = S_HOLD;
        end
        S_HOLD: begin
          state_d = S_HOLD;
        end
        default: state_d = S_WAIT_VSYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_WAIT_VSYNC;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      skip_q       <= '0;
      hb_q         <= 1'b0;
      vb_q         <= 1'b0;
      vs_q         <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      lines_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      skip_q       <= skip_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      fb_we_q      <= fb_we_d;
      frame_done_q <= frame_done_d;
      lines_q      <= lines_d;
      if (pix_ce) begin
        hb_q <= tia_hblank;
        vb_q <= tia_vblank;
        vs_q <= tia_vsync;
      end
    end
  end

  assign fb_addr        = fb_addr_q;
  assign fb_data        = fb_data_q;
  assign fb_we          = fb_we_q;
  assign frame_done     = frame_done_q;
  assign lines_captured = lines_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_tia_frame_capture.sv
// Directed bench for tia_frame_capture: synthetic, long, skipped and
// interrupted frames checked against a scoreboard of expected writes.
module tb_tia_frame_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_ce;
  logic [6:0]  tia_color;
  logic        tia_hblank, tia_vblank, tia_vsync;
  logic [15:0] fb_addr, s_fb_addr;
  logic [6:0]  fb_data, s_fb_data;
  logic        fb_we, s_fb_we;
  logic        frame_done, s_frame_done;
  logic [8:0]  lines_captured, s_lines_captured;
  logic [2:0]  dbg_state, s_dbg_state;

  always #5 clk = ~clk;

  tia_frame_capture #(.H_PIXELS(160), .V_LINES(240), .V_SKIP(0), .AW(16)) dut (
    .clk(clk), .reset(rst_n), .pix_ce(pix_ce), .tia_color(tia_color),
    .tia_hblank(tia_hblank), .tia_vblank(tia_vblank), .tia_vsync(tia_vsync),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .frame_done(frame_done), .lines_captured(lines_captured),
    .dbg_state_o(dbg_state)
  );

  tia_frame_capture #(.H_PIXELS(160), .V_LINES(240), .V_SKIP(2), .AW(16)) dut_s (
    .clk(clk), .reset(rst_n), .pix_ce(pix_ce), .tia_color(tia_color),
    .tia_hblank(tia_hblank), .tia_vblank(tia_vblank), .tia_vsync(tia_vsync),
    .fb_addr(s_fb_addr), .fb_data(s_fb_data), .fb_we(s_fb_we),
    .frame_done(s_frame_done), .lines_captured(s_lines_captured),
    .dbg_state_o(s_dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: {addr[15:0], data[6:0]}
  logic [22:0] exp_q[$];
  logic [22:0] exp_w;
  int          wr_cnt, oob_cnt, fd_cnt;
  logic [15:0] last_addr;
  logic [8:0]  fd_lc;
  logic        cap_seen;
  logic [6:0]  cap_data;
  int          s_wr_cnt;
  logic [15:0] s_first_addr, s_last_addr;
  logic [6:0]  s_first_data;
  logic [8:0]  s_fd_lc;
  int          gap = 0;

  always @(negedge clk) begin
    if (fb_we) begin
      wr_cnt++;
      last_addr = fb_addr;
      if (fb_addr >= 16'd38400) oob_cnt++;
      if (fb_addr == 16'd1605) begin
        cap_seen = 1'b1;
        cap_data = fb_data;
      end
      if (exp_q.size() == 0) begin
        check("wr_unexpected_q_size", 32'd0, 32'd1);
      end else begin
        exp_w = exp_q.pop_front();
        check("wr_addr", 32'(fb_addr), 32'(exp_w[22:7]));
        check("wr_data", 32'(fb_data), 32'(exp_w[6:0]));
      end
    end
    if (frame_done) begin
      fd_cnt++;
      fd_lc = lines_captured;
    end
    if (s_fb_we) begin
      if (s_wr_cnt == 0) begin
        s_first_addr = s_fb_addr;
        s_first_data = s_fb_data;
      end
      s_last_addr = s_fb_addr;
      s_wr_cnt++;
    end
    if (s_frame_done) s_fd_lc = s_lines_captured;
  end

  task automatic cc(input logic hb, input logic vb, input logic vs, input logic [6:0] col);
    tia_hblank = hb;
    tia_vblank = vb;
    tia_vsync  = vs;
    tia_color  = col;
    pix_ce     = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic line(input int row, input int hbl, input int npix,
                      input logic vb, input logic vs, input bit vis);
    logic [6:0] col;
    for (int h = 0; h < hbl; h++) cc(1'b1, vb, vs, 7'd0);
    for (int x = 0; x < npix; x++) begin
      col = 7'((x + row) & 127);
      if (vis && row < 240 && x < 160) exp_q.push_back({16'(row * 160 + x), col});
      cc(1'b0, vb, vs, col);
    end
  endtask

  function automatic int row_len(input int mode, input int r);
    if (mode == 0) return 160;
    if (mode == 1) return (r < 236) ? 3 : 170;
    return 10;
  endfunction

  task automatic idle(input int n);
    pix_ce = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // vsync, vblank, visible rows, trailing hblank, overscan, then the next vsync rise.
  task automatic frame(input int mode, input int nvis, input int hbl);
    for (int i = 0; i < 3; i++)  line(0, 4, 6, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 37; i++) line(0, 4, 6, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < nvis; r++) line(r, hbl, row_len(mode, r), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)  cc(1'b1, 1'b0, 1'b0, 7'd0);
    for (int i = 0; i < 2; i++)  line(0, 4, 6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)  cc(1'b1, 1'b1, 1'b1, 7'd0);
    idle(3);
  endtask

  task automatic clear_counts();
    wr_cnt   = 0;
    oob_cnt  = 0;
    fd_cnt   = 0;
    s_wr_cnt = 0;
    cap_seen = 1'b0;
  endtask

  int wr_base;

  initial begin
    rst_n = 1'b0;
    pix_ce = 1'b0;
    tia_hblank = 1'b1;
    tia_vblank = 1'b1;
    tia_vsync  = 1'b1;
    tia_color  = 7'h55;
    clear_counts();

    // Reset held low with pix_ce toggling and all syncs asserted
    for (int i = 0; i < 3; i++) begin
      pix_ce = (i % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      check("rst_fb_we", 32'(fb_we), 32'd0);
      check("rst_fb_addr", 32'(fb_addr), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
    end
    rst_n = 1'b1;
    pix_ce = 1'b0;
    tia_hblank = 1'b0;
    tia_vblank = 1'b0;
    tia_vsync  = 1'b0;
    tia_color  = 7'd0;
    @(posedge clk); @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_lines", 32'(lines_captured), 32'd0);
    check("rst_fb_we_after", 32'(fb_we), 32'd0);

    // Synthetic 192-line frame, 68 hblank + 160 pixels per line
    clear_counts();
    frame(0, 192, 68);
    check("syn_writes", wr_cnt, 30720);
    check("syn_frame_done", fd_cnt, 1);
    check("syn_lines", 32'(fd_lc), 32'd192);
    check("syn_pix_5_10_seen", 32'(cap_seen), 32'd1);
    check("syn_pix_5_10_data", 32'(cap_data), 32'd15);
    check("syn_q_drained", exp_q.size(), 0);

    // 260 visible lines: short rows, then 170-pixel rows from row 236
    clear_counts();
    frame(1, 260, 4);
    check("long_writes", wr_cnt, 236 * 3 + 4 * 160);
    check("long_oob", oob_cnt, 0);
    check("long_last_addr", 32'(last_addr), 32'd38399);
    check("long_frame_done", fd_cnt, 1);
    check("long_lines", 32'(fd_lc), 32'd240);
    check("long_q_drained", exp_q.size(), 0);

    // Five 10-pixel rows with pix_ce every other clock; the V_SKIP=2 copy drops two
    clear_counts();
    gap = 1;
    frame(2, 5, 4);
    gap = 0;
    check("skip0_writes", wr_cnt, 50);
    check("skip0_lines", 32'(fd_lc), 32'd5);
    check("skip2_writes", s_wr_cnt, 30);
    check("skip2_first_addr", 32'(s_first_addr), 32'd0);
    check("skip2_first_data", 32'(s_first_data), 32'd2);
    check("skip2_last_addr", 32'(s_last_addr), 32'd329);
    check("skip2_lines", 32'(s_fd_lc), 32'd3);
    check("skip_q_drained", exp_q.size(), 0);

    // vsync rise together with hblank at pixel 80 of row 50, then a 1-clk reset
    clear_counts();
    for (int i = 0; i < 2; i++) line(0, 4, 6, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 50; r++) line(r, 4, 10, 1'b0, 1'b0, 1'b1);
    line(50, 4, 80, 1'b0, 1'b0, 1'b1);
    cc(1'b1, 1'b0, 1'b1, 7'd0);
    @(negedge clk);
    check("mid_frame_done", 32'(frame_done), 32'd1);
    check("mid_lines", 32'(lines_captured), 32'd50);
    check("mid_writes", wr_cnt, 580);
    rst_n = 1'b0;
    cc(1'b0, 1'b0, 1'b0, 7'd5);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_fb_we", 32'(fb_we), 32'd0);
    check("mid_rst_fb_addr", 32'(fb_addr), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check("mid_rst_lines", 32'(lines_captured), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_pulse_width", fd_cnt, 1);

    // No writes until vsync rise then vblank fall, even across a vblank fall
    wr_base = wr_cnt;
    fd_cnt  = 0;
    line(0, 4, 10, 1'b0, 1'b0, 1'b0);
    line(0, 4, 6, 1'b1, 1'b0, 1'b0);
    line(1, 4, 10, 1'b0, 1'b0, 1'b0);
    check("post_rst_no_writes", wr_cnt - wr_base, 0);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    line(0, 4, 6, 1'b1, 1'b1, 1'b0);
    check("post_rst_vsync_no_pulse", fd_cnt, 0);
    line(0, 4, 6, 1'b1, 1'b0, 1'b0);
    line(0, 4, 10, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cc(1'b1, 1'b0, 1'b0, 7'd0);
    idle(3);
    check("resume_writes", wr_cnt - wr_base, 10);
    check("resume_state", 32'(dbg_state), 32'd3);
    check("resume_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
